// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Purpose : groups the ID-stage request signals and the pipeline-control
//           responses exchanged between the decode stage and the hazard
//           scoreboard.
// Signals : id_valid_i, id_rs_i/id_rs_use_i, id_rt_i/id_rt_use_i,
//           id_rd_i/id_rd_wr_i, id_lat_i, flush_i   (ID stage -> scoreboard)
//           pc_write_o, if_id_write_o, bubble_o, busy_o (scoreboard -> pipe)
// Modports: master = decode/pipeline side, slave = scoreboard.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 3
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic              id_rs_use_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_rt_use_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_rd_wr_i;
  logic [LAT_W-1:0]  id_lat_i;
  logic              flush_i;
  logic              pc_write_o;
  logic              if_id_write_o;
  logic              bubble_o;
  logic              busy_o;

  modport master (
    output id_valid_i, id_rs_i, id_rs_use_i, id_rt_i, id_rt_use_i,
           id_rd_i, id_rd_wr_i, id_lat_i, flush_i,
    input  pc_write_o, if_id_write_o, bubble_o, busy_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rs_use_i, id_rt_i, id_rt_use_i,
           id_rd_i, id_rd_wr_i, id_lat_i, flush_i,
    output pc_write_o, if_id_write_o, bubble_o, busy_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Purpose : ID-stage hazard detector. Keeps a down-counter per architectural
//           register holding the cycles until its pending result becomes
//           forwardable, and stalls the ID instruction on RAW hazards and on
//           WAW ordering hazards (a younger result must not be ready before an
//           older one to the same register).
// Ports   : clk_i        rising-edge clock
//           rst_i        asynchronous active-high reset (clears all counters)
//           bus          hazard_scoreboard_if.slave (ID request / pipe control)
//           stall_cnt_o  [31:0] saturating count of stalled cycles
//                        (present only when HD_STALL_CNT_EN is defined)
// Options : `define HD_STALL_CNT_EN to add the stall_cnt_o performance counter.
// All outputs on the bus are combinational from the counters and ID inputs.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 4,
  parameter int LAT_W   = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  hazard_scoreboard_if.slave bus
`ifdef HD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

  logic [LAT_W-1:0] r_cnt [NREG];

  logic [LAT_W-1:0] w_lat_eff;
  logic             w_raw_rs;
  logic             w_raw_rt;
  logic             w_waw;
  logic             w_stall;
  logic             w_issue;
  logic             w_busy;
  logic             w_wr_en;

  // Clamp so a counter can never be loaded beyond the tracked range.
  assign w_lat_eff = (bus.id_lat_i > MAX_LAT_V) ? MAX_LAT_V : bus.id_lat_i;

  // Register 0 is hardwired zero and never produces a hazard.
  assign w_raw_rs = bus.id_rs_use_i && (bus.id_rs_i != '0) && (r_cnt[bus.id_rs_i] != '0);
  assign w_raw_rt = bus.id_rt_use_i && (bus.id_rt_i != '0) && (r_cnt[bus.id_rt_i] != '0);
  // An in-flight older result finishing after this one would overwrite it.
  assign w_waw    = bus.id_rd_wr_i && (bus.id_rd_i != '0) && (r_cnt[bus.id_rd_i] > w_lat_eff);

  // Flush dominates: a squashed instruction neither stalls nor issues.
  assign w_stall  = bus.id_valid_i && !bus.flush_i && (w_raw_rs || w_raw_rt || w_waw);
  assign w_issue  = bus.id_valid_i && !w_stall && !bus.flush_i;
  assign w_wr_en  = w_issue && bus.id_rd_wr_i && (bus.id_rd_i != '0);

  always_comb begin
    w_busy = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (r_cnt[r] != '0) w_busy = 1'b1;
    end
  end

  assign bus.pc_write_o    = !w_stall;
  assign bus.if_id_write_o = !w_stall;
  assign bus.bubble_o      = w_stall || bus.flush_i;
  assign bus.busy_o        = w_busy;

  // Per-register counters: a newly issued write reloads its entry (lat 0
  // clears it); every other entry counts down and holds at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      r_cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (w_wr_en && (bus.id_rd_i == REG_AW'(r))) begin
          r_cnt[r] <= w_lat_eff;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

`ifdef HD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Self-checking bench for hazard_scoreboard. The reference model records, per
// register, the absolute cycle at which its pending result becomes
// forwardable; pending time is derived from the current cycle number.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
  localparam int REG_AW  = 5;
  localparam int MAX_LAT = 4;
  localparam int LAT_W   = 3;
  localparam int NREG    = 1 << REG_AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(REG_AW), .LAT_W(LAT_W)) hif ();

`ifdef HD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_scoreboard #(.REG_AW(REG_AW), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (hif)
`ifdef HD_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint now = 0;
  longint ready [NREG];
  longint model_stalls = 0;
  bit     e_stall, e_issue, e_busy, e_bubble;
  int     m_rd, m_lat;
  bit     m_wr;

  function automatic int pend(int r);
    if (r == 0) return 0;
    if (ready[r] > now) return int'(ready[r] - now);
    return 0;
  endfunction

  function automatic int lat_eff(int l);
    return (l > MAX_LAT) ? MAX_LAT : l;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) ready[r] = 0;
    model_stalls = 0;
  endtask

  task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input int rd, input bit wr, input int lat, input bit fl);
    bit hz;
    hif.id_valid_i  = v;
    hif.id_rs_i     = REG_AW'(rs);
    hif.id_rs_use_i = rsu;
    hif.id_rt_i     = REG_AW'(rt);
    hif.id_rt_use_i = rtu;
    hif.id_rd_i     = REG_AW'(rd);
    hif.id_rd_wr_i  = wr;
    hif.id_lat_i    = LAT_W'(lat);
    hif.flush_i     = fl;
    m_rd  = rd;
    m_wr  = wr;
    m_lat = lat_eff(lat);
    hz = (rsu && pend(rs) > 0) || (rtu && pend(rt) > 0) || (wr && pend(rd) > m_lat);
    e_stall  = v && !fl && hz;
    e_issue  = v && !e_stall && !fl;
    e_bubble = e_stall || fl;
    e_busy   = 1'b0;
    for (int r = 1; r < NREG; r++) if (pend(r) > 0) e_busy = 1'b1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock and apply the effect of the driven instruction.
  task automatic tick();
    @(posedge clk);
    if (e_stall) model_stalls++;
    if (e_issue && m_wr && m_rd != 0) ready[m_rd] = now + 1 + m_lat;
    now++;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (6) tick();
    idle();
  endtask

  // Caller is at a negedge with a consumer driven; counts stalled cycles
  // until the instruction can issue (bounded).
  task automatic wait_issue(output int n);
    n = 0;
    while (!hif.pc_write_o && n < 20) begin
      n++;
      tick();
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1),
            $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom_range(0, 1), $urandom_range(0, 7), 0);
      #1;
      checks++;
      if (hif.pc_write_o !== 1'b1 || hif.if_id_write_o !== 1'b1 ||
          hif.bubble_o !== 1'b0 || hif.busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: pc=%b ifid=%b bub=%b busy=%b, want 1 1 0 0",
                 hif.pc_write_o, hif.if_id_write_o, hif.bubble_o, hif.busy_o);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1, $urandom_range(1, 31), 1, $urandom_range(1, 31), 1, 0, 0, 0, 0);
    #1;
    checks++;
    if (hif.pc_write_o !== 1'b1 || hif.if_id_write_o !== 1'b1 ||
        hif.bubble_o !== 1'b0 || hif.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: pc=%b ifid=%b bub=%b busy=%b, want 1 1 0 0",
               hif.pc_write_o, hif.if_id_write_o, hif.bubble_o, hif.busy_o);
    end
`ifdef HD_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
    tick();
    drain();
  endtask

  task automatic test_load_use();
    int n;
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (hif.pc_write_o !== 1'b0 || hif.if_id_write_o !== 1'b0 || hif.bubble_o !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: pc=%b ifid=%b bub=%b want 0 0 1",
               hif.pc_write_o, hif.if_id_write_o, hif.bubble_o);
    end
    wait_issue(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL load_use_cycles: got %0d want 1", n);
    end
    checks++;
    if (hif.busy_o !== 1'b0 || hif.bubble_o !== 1'b0) begin
      errors++;
      $display("FAIL load_use_release: busy=%b bub=%b want 0 0", hif.busy_o, hif.bubble_o);
    end
    tick();
    drain();
  endtask

  task automatic test_long_latency();
    int n;
    int lats [2] = '{3, 7};
    int exps [2] = '{3, 4};
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 0, 7, 1, lats[k], 0);
      tick();
      drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
      @(negedge clk);
      wait_issue(n);
      checks++;
      if (n !== exps[k]) begin
        errors++;
        $display("FAIL long_lat_%0d: got %0d stall cycles want %0d", lats[k], n, exps[k]);
      end
      tick();
      drain();
    end
  endtask

  task automatic test_waw();
    int n;
    drive(1, 0, 0, 0, 0, 9, 1, 4, 0);
    tick();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
    @(negedge clk);
    wait_issue(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL waw_cycles: got %0d want 4", n);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (hif.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL waw_cleared: busy=%b want 0", hif.busy_o);
    end
    drain();
  endtask

  task automatic test_reg0();
    drive(1, 0, 0, 0, 0, 0, 1, 4, 0);
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (hif.pc_write_o !== 1'b1 || hif.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reg0: pc=%b busy=%b want 1 0", hif.pc_write_o, hif.busy_o);
    end
    tick();
    drain();
  endtask

  task automatic test_flush();
    int n;
    drive(1, 0, 0, 0, 0, 3, 1, 2, 0);
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checks++;
    if (hif.bubble_o !== 1'b1 || hif.pc_write_o !== 1'b1 ||
        hif.if_id_write_o !== 1'b1 || hif.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_ctrl: bub=%b pc=%b ifid=%b busy=%b want 1 1 1 1",
               hif.bubble_o, hif.pc_write_o, hif.if_id_write_o, hif.busy_o);
    end
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    wait_issue(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL flush_decrement: got %0d stall cycles want 1", n);
    end
    tick();
`ifdef HD_STALL_CNT_EN
    #1;
    checks++;
    if (stall_cnt !== 32'(model_stalls)) begin
      errors++;
      $display("FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, model_stalls);
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 0, 0, 0, 0, 4, 1, 4, 0);
    tick();
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (hif.pc_write_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_stall_pre: pc=%b want 0", hif.pc_write_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (hif.pc_write_o !== 1'b1 || hif.bubble_o !== 1'b0 || hif.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_stall_reset: pc=%b bub=%b busy=%b want 1 0 0",
               hif.pc_write_o, hif.bubble_o, hif.busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (hif.pc_write_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_stall_after: pc=%b want 1", hif.pc_write_o);
    end
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7) == 0);
      @(negedge clk);
      checks++;
      if (hif.pc_write_o !== !e_stall || hif.if_id_write_o !== !e_stall) begin
        errors++;
        $display("FAIL rand_pc cyc %0d: pc=%b ifid=%b want %b", i,
                 hif.pc_write_o, hif.if_id_write_o, !e_stall);
      end
      checks++;
      if (hif.bubble_o !== e_bubble) begin
        errors++;
        $display("FAIL rand_bubble cyc %0d: got %b want %b", i, hif.bubble_o, e_bubble);
      end
      checks++;
      if (hif.busy_o !== e_busy) begin
        errors++;
        $display("FAIL rand_busy cyc %0d: got %b want %b", i, hif.busy_o, e_busy);
      end
      tick();
    end
`ifdef HD_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'(model_stalls)) begin
      errors++;
      $display("FAIL rand_stall_cnt: got %0d want %0d", stall_cnt, model_stalls);
    end
`endif
    drain();
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    idle();
    test_reset();
    test_load_use();
    test_long_latency();
    test_waw();
    test_reg0();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-load-use hazard detector in the ID stage.
- Tracks every architectural register with a pending long-latency result using a per-register down-counter.
- Stalls the instruction in ID on RAW hazards against any in-flight result of latency 1..MAX_LAT, and on WAW ordering hazards.
- Drives PC write enable, IF/ID write enable and the ID/EX bubble-select mux.

Parameters:
- REG_AW, 5, register address width; tracked registers = 2**REG_AW.
- MAX_LAT, 4, largest result latency in cycles (1 = classic load-use).
- LAT_W, 3, width of the latency field and counters; must satisfy 2**LAT_W > MAX_LAT.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  REG_AW  source register rs.
- id_rs_use_i  in  1  instruction reads rs.
- id_rt_i  in  REG_AW  source register rt.
- id_rt_use_i  in  1  instruction reads rt.
- id_rd_i  in  REG_AW  destination register.
- id_rd_wr_i  in  1  instruction writes rd.
- id_lat_i  in  LAT_W  cycles until the result is forwardable; 0 = fully forwardable (ALU op).
- flush_i  in  1  ID instruction is squashed this cycle (taken branch).
- pc_write_o  out  1  1 = PC may update.
- if_id_write_o  out  1  1 = IF/ID register may update.
- bubble_o  out  1  1 = select zero controls into ID/EX.
- busy_o  out  1  at least one counter is non-zero.

Behaviour:
- State: cnt[r], LAT_W bits, for r = 0..2**REG_AW-1. Register 0 is never tracked; cnt[0] stays 0.
- Reset (async, rst_i=1): all cnt = 0.
  - Outputs during and after reset: pc_write_o=1, if_id_write_o=1, bubble_o=0, busy_o=0.
  - Reset asserted mid-stall clears all pending state immediately; the stall releases in the same cycle.
- Latency input: lat_eff = min(id_lat_i, MAX_LAT).
- Hazards, all combinational from current cnt and ID inputs:
  - raw_rs = id_rs_use_i & (id_rs_i != 0) & (cnt[id_rs_i] != 0).
  - raw_rt is defined the same way for rt.
  - waw = id_rd_wr_i & (id_rd_i != 0) & (cnt[id_rd_i] > lat_eff). A younger result must never be ready before an older one.
  - stall = id_valid_i & ~flush_i & (raw_rs | raw_rt | waw).
- Outputs:
  - pc_write_o = ~stall.
  - if_id_write_o = ~stall.
  - bubble_o = stall | flush_i.
  - busy_o = OR of all cnt != 0.
  - No output is registered: zero-cycle latency from inputs.
- Issue: issue = id_valid_i & ~stall & ~flush_i.
- Counter update on each rising clock edge:
  - If issue & id_rd_wr_i & (id_rd_i != 0): cnt[id_rd_i] <= lat_eff. This overrides the decrement for that entry, and lat_eff = 0 clears it.
  - Every other entry with cnt != 0 decrements by 1, saturating at 0.
  - A stalled or flushed instruction never writes the scoreboard.
- Equivalence to the previous generation: a load with lat=1 followed by a dependent instruction stalls exactly 1 cycle. A lat=N producer stalls an immediately following consumer for N cycles.
- Simultaneous events:
  - flush_i overrides stall: bubble_o=1, PC/IF-ID enabled, no issue.
  - rs == rt == a pending rd counts as a single hazard.
  - An instruction reading and writing the same pending register stalls on RAW first.
- Counters never wrap: decrement saturates at 0, and lat_eff is clamped to MAX_LAT.

Optional Feature:
- Macro HD_STALL_CNT_EN.
- Defined: adds output port stall_cnt_o [31:0].
  - Increments by 1 every cycle where stall=1.
  - Saturates at 32'hFFFF_FFFF.
  - Async-reset to 0 by rst_i.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Reset test: assert rst_i with random inputs -> cnt all 0, pc_write_o=1, if_id_write_o=1, bubble_o=0, busy_o=0. Deassert -> same values, with no spurious stall.
- Load-use, 1 cycle: issue rd=5, lat=1, then ID rs=5 use=1 -> stall for exactly 1 cycle (pc_write_o=0, bubble_o=1). Next cycle issues. busy_o drops after that cycle.
- Long latency with clamp: issue rd=7, lat=3, then consumer rt=7 -> 3 stall cycles. Repeat with lat=7 and MAX_LAT=4 -> 4 stall cycles.
- WAW: issue rd=9 lat=4, then ALU op rd=9 lat=0 with no sources -> stall until cnt[9]=0 (4 cycles), then it issues with cnt[9]=0.
- Register 0: issue rd=0 lat=4, then consumer rs=0 -> no stall, busy_o=0.
- Flush during stall: cnt[3]=2 with consumer rs=3 in ID; assert flush_i -> bubble_o=1, pc_write_o=1, cnt[3] still decrements to 1. With HD_STALL_CNT_EN defined, stall_cnt_o counts only stalled cycles (flush cycle excluded).
